instr_encoder_stream: RTL and testbench

// - Inverse of the instruction decoder: packs group/ra/rb/rc/opcode/imm fields into 32-bit instruction words.
// - Sits between the test/boot loader and instruction memory. Streams encoded words with a target address over valid/ready.
// - 2-entry skid buffer gives full throughput. Illegal groups are dropped and flagged.

---
 rtl/instr_encoder_stream.sv | 158 +++++++++++++++
 tb/tb_instr_encoder_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_stream.sv
// instr_encoder_stream
//   Packs group/ra/rb/rc/opcode/imm fields into 32-bit instruction words and
//   streams them, each with its target instruction-memory address, over a
//   valid/ready interface. A 2-entry skid buffer sustains one word per cycle.
//   Words with an illegal group (>3) are accepted, dropped and flagged.
//
// Parameters
//   ADDR_WIDTH  width of the instruction-memory word address
//   START_ADDR  address assigned to the first word after reset or clr
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous clear of buffer, address and error state
//   in_valid/in_ready   input handshake (in_ready is registered)
//   in_group, in_ra, in_rb, in_rc, in_opcode, in_imm   instruction fields
//   out_valid/out_ready output handshake
//   out_word, out_addr  encoded word and its memory address
//   err_group           sticky flag: an illegal group was dropped
//   err_count           (only with INSTR_ENCODER_ERR_COUNT_EN) saturating
//                       count of dropped illegal inputs
//
// Build option
//   INSTR_ENCODER_ERR_COUNT_EN  adds the err_count output and its counter.
module instr_encoder_stream #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_group,
  input  logic [3:0]            in_ra,
  input  logic [3:0]            in_rb,
  input  logic [3:0]            in_rc,
  input  logic [3:0]            in_opcode,
  input  logic [15:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_word,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_group
`ifdef INSTR_ENCODER_ERR_COUNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);

  function automatic logic [31:0] encode(
    input logic [3:0]  grp,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [3:0]  rc,
    input logic [3:0]  op,
    input logic [15:0] imm
  );
    if (grp == 4'd1)
      return {4'h1, ra, rb, op, imm};
    else
      return {grp, ra, rb, rc, 12'h000, op};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]            occ_q;
  logic [1:0]            occ_next;
  logic [31:0]           slot0_q;
  logic [31:0]           slot1_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  in_ready_q;
  logic                  err_q;
  logic                  legal;
  logic                  in_fire;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic [31:0]           enc_word;

  // ---- input stage: encode and classify the offered field set
  always_comb begin
    legal    = (in_group[3:2] == 2'b00);
    in_fire  = in_valid & in_ready_q;
    push     = in_fire & legal;
    drop     = in_fire & ~legal;
    pop      = (occ_q != 2'd0) & out_ready;
    enc_word = encode(in_group, in_ra, in_rb, in_rc, in_opcode, in_imm);
    occ_next = occ_q;
    if (push && !pop)
      occ_next = occ_q + 2'd1;
    else if (!push && pop)
      occ_next = occ_q - 2'd1;
  end

  // ---- buffer control: occupancy, address, ready and error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      addr_q     <= START_A;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (clr) begin
      occ_q      <= 2'd0;
      addr_q     <= START_A;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_next;
      in_ready_q <= (occ_next != 2'd2);
      if (pop)
        addr_q <= addr_q + 1'b1;
      if (drop)
        err_q <= 1'b1;
    end
  end

`ifdef INSTR_ENCODER_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= 8'h00;
    else if (clr)
      err_cnt_q <= 8'h00;
    else if (drop)
      err_cnt_q <= sat_inc8(err_cnt_q);
  end

  assign err_count = err_cnt_q;
`endif

  // ---- buffer data: slot0 is the head, slot1 the skid entry.
  // A push at occupancy 2 cannot happen because in_ready is low then.
  always_ff @(posedge clk) begin
    if (push && (occ_q == 2'd0 || (occ_q == 2'd1 && pop)))
      slot0_q <= enc_word;
    else if (pop && occ_q == 2'd2)
      slot0_q <= slot1_q;
    if (push && occ_q == 2'd1 && !pop)
      slot1_q <= enc_word;
  end

  // ---- output stage
  // out_word is forced to zero when no word is presented, so the data
  // slots themselves need no reset.
  always_comb begin
    out_valid = (occ_q != 2'd0);
    out_word  = out_valid ? slot0_q : 32'h0;
    out_addr  = addr_q;
    in_ready  = in_ready_q;
    err_group = err_q;
  end

endmodule

// File: tb/tb_instr_encoder_stream.sv
// Directed bench for instr_encoder_stream (ADDR_WIDTH=4, START_ADDR=0).
module tb_instr_encoder_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_group, in_ra, in_rb, in_rc, in_opcode;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_addr;
  logic        err_group;
`ifdef INSTR_ENCODER_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  instr_encoder_stream #(.ADDR_WIDTH(4), .START_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_group  (in_group),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_rc     (in_rc),
    .in_opcode (in_opcode),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .err_group (err_group)
`ifdef INSTR_ENCODER_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] g, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rc,
                        input logic [3:0] op, input logic [15:0] imm);
    in_valid  = v;
    in_group  = g;
    in_ra     = ra;
    in_rb     = rb;
    in_rc     = rc;
    in_opcode = op;
    in_imm    = imm;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [3:0]  ra_i, rb_i, op_i;
    logic [31:0] exp_w;

    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_word",  out_word,       32'h0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_err_group", 32'(err_group), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // group 0 encoding, latency of one cycle
    out_ready = 1'b1;
    set_in(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 16'h0);
    step();
    in_valid = 1'b0;
    chk("g0_valid", 32'(out_valid), 32'd1);
    chk("g0_word",  out_word,       32'h0123_0005);
    chk("g0_addr",  32'(out_addr),  32'd0);
    step();
    chk("g0_popped", 32'(out_valid), 32'd0);
    chk("g0_addr_inc", 32'(out_addr), 32'd1);

    // group 1 encoding, rc ignored
    set_in(1'b1, 4'h1, 4'h4, 4'h5, 4'hF, 4'h2, 16'hBEEF);
    step();
    in_valid = 1'b0;
    chk("g1_word", out_word,      32'h1452_BEEF);
    chk("g1_addr", 32'(out_addr), 32'd1);
    step();

    // backpressure: three words back to back with out_ready low
    do_clr();
    chk("clr_addr",     32'(out_addr),  32'd0);
    chk("clr_in_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b0;
    set_in(1'b1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 16'h0);
    step();
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    chk("bp_w0",   out_word,      32'h2678_0009);
    set_in(1'b1, 4'h3, 4'hA, 4'hB, 4'hC, 4'hD, 16'h0);
    step();
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    set_in(1'b1, 4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 16'h0);
    step();
    chk("bp_hold_word", out_word,      32'h2678_0009);
    chk("bp_hold_addr", 32'(out_addr), 32'd0);
    chk("bp_hold_rdy",  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_w1",      out_word,      32'h3ABC_000D);
    chk("bp_w1_addr", 32'(out_addr), 32'd1);
    chk("bp_rdy_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_w2",      out_word,      32'h0FED_000C);
    chk("bp_w2_addr", 32'(out_addr), 32'd2);
    step();
    chk("bp_empty",   32'(out_valid), 32'd0);
    chk("bp_addr3",   32'(out_addr),  32'd3);

    // 17 words streamed continuously: address wraps 15 -> 0, no bubbles
    do_clr();
    for (int i = 0; i < 17; i++) begin
      ra_i = 4'(i);
      rb_i = ~4'(i);
      op_i = 4'(i) ^ 4'h3;
      set_in(1'b1, 4'h0, ra_i, rb_i, 4'h5, op_i, 16'h0);
      step();
      exp_w = {4'h0, ra_i, rb_i, 4'h5, 12'h000, op_i};
      chk($sformatf("wrap_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("wrap_word_%0d", i),  out_word,       exp_w);
      chk($sformatf("wrap_addr_%0d", i),  32'(out_addr),  32'(i % 16));
    end
    in_valid = 1'b0;
    step();
    chk("wrap_done", 32'(out_valid), 32'd0);

    // illegal group between two legal words
    do_clr();
    set_in(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 16'h0);
    step();
    chk("ill_a_word", out_word,       32'h0123_0005);
    chk("ill_a_addr", 32'(out_addr),  32'd0);
    chk("ill_err0",   32'(err_group), 32'd0);
    set_in(1'b1, 4'h7, 4'h9, 4'h9, 4'h9, 4'h9, 16'h9999);
    step();
    chk("ill_dropped", 32'(out_valid), 32'd0);
    chk("ill_err1",    32'(err_group), 32'd1);
    chk("ill_addr",    32'(out_addr),  32'd1);
    set_in(1'b1, 4'h1, 4'h2, 4'h3, 4'h0, 4'h4, 16'h1234);
    step();
    in_valid = 1'b0;
    chk("ill_b_word", out_word,      32'h1234_1234);
    chk("ill_b_addr", 32'(out_addr), 32'd1);
`ifdef INSTR_ENCODER_ERR_COUNT_EN
    chk("ill_err_count", 32'(err_count), 32'd1);
`endif
    step();
    chk("ill_end", 32'(out_valid), 32'd0);

    // clr with two words buffered, competing with a push and a pop
    out_ready = 1'b0;
    set_in(1'b1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 16'h0);
    step();
    set_in(1'b1, 4'h3, 4'h2, 4'h2, 4'h2, 4'h2, 16'h0);
    step();
    chk("clr_pre_full", 32'(in_ready), 32'd0);
    clr = 1'b1;
    out_ready = 1'b1;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_rdy",   32'(in_ready),  32'd1);
    chk("clr_addr0", 32'(out_addr),  32'd0);
    chk("clr_err",   32'(err_group), 32'd0);
`ifdef INSTR_ENCODER_ERR_COUNT_EN
    chk("clr_err_count", 32'(err_count), 32'd0);
`endif
    set_in(1'b1, 4'h0, 4'h4, 4'h3, 4'h2, 4'h1, 16'h0);
    step();
    in_valid = 1'b0;
    chk("clr_next_word", out_word,      32'h0432_0001);
    chk("clr_next_addr", 32'(out_addr), 32'd0);
    step();

    // asynchronous reset with two words buffered
    out_ready = 1'b0;
    set_in(1'b1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 16'h0);
    step();
    set_in(1'b1, 4'h3, 4'h2, 4'h2, 4'h2, 4'h2, 16'h0);
    step();
    in_valid = 1'b0;
    chk("rst2_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_async_valid", 32'(out_valid), 32'd0);
    chk("rst2_async_rdy",   32'(in_ready),  32'd0);
    chk("rst2_async_word",  out_word,       32'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rst2_rdy",  32'(in_ready), 32'd1);
    chk("rst2_addr", 32'(out_addr), 32'd0);
    set_in(1'b1, 4'h0, 4'h8, 4'h7, 4'h6, 4'h5, 16'h0);
    step();
    in_valid = 1'b0;
    chk("rst2_word",      out_word,      32'h0876_0005);
    chk("rst2_word_addr", 32'(out_addr), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
